// File: rtl/frame_acc_pkg.sv
// Shared state/bank types and index-width helpers for the frame accumulator.
package frame_acc_pkg;

  typedef enum logic {FILL, WAIT} state_t;
  typedef logic bank_t;

  function automatic int SAMPLE_W(input int n_samples);
    return (n_samples > 1) ? $clog2(n_samples) : 1;
  endfunction

  function automatic int CHAN_W(input int n_channels);
    return (n_channels > 1) ? $clog2(n_channels) : 1;
  endfunction

endpackage

// File: rtl/frame_accumulator_up_counter.sv
// Wrapping up-counter with synchronous clear; wrap flags the increment that returns it to zero.
module up_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    wrap    = inc && (count_q == W'(MAX));
    count_d = count_q;
    if (clr || wrap) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_accumulator_word_assembler.sv
// Shifts IN_WIDTH beats MSB-first into a WORD_WIDTH word; word_vld pulses the cycle after the last beat.
module word_assembler #(
  parameter int IN_WIDTH   = 2,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat_vld,
  input  logic [IN_WIDTH-1:0]   beat_dat,
  output logic                  word_vld,
  output logic [WORD_WIDTH-1:0] word_dat
);

  localparam int BEATS = WORD_WIDTH / IN_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [WORD_WIDTH-1:0] shift_q, shift_d, word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    vld_d   = 1'b0;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (beat_vld) begin
      shift_d = WORD_WIDTH'({shift_q, beat_dat});
      if (cnt_q == CNT_W'(BEATS - 1)) begin
        cnt_d  = '0;
        vld_d  = 1'b1;
        word_d = shift_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

  assign word_vld = vld_q;
  assign word_dat = word_q;

endmodule

// File: rtl/frame_accumulator.sv
// Assembles serial beats into words and fills ping-pong N_SAMPLES x N_CHANNELS frames.
// The oldest complete frame is held for addressed, registered readout until released.
module frame_accumulator
  import frame_acc_pkg::*;
#(
  parameter int N_SAMPLES     = 512,
  parameter int N_CHANNELS    = 8,
  parameter int WORD_WIDTH    = 32,
  parameter int IN_WIDTH      = 2,
  parameter int DOUBLE_BUFFER = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           in_valid,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           flush,
  input  logic                           rd_en,
  input  logic [SAMPLE_W(N_SAMPLES)-1:0] rd_sample,
  input  logic [CHAN_W(N_CHANNELS)-1:0]  rd_channel,
  output logic [WORD_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic                           frame_ready,
  input  logic                           frame_release,
  output logic                           overrun,
  output logic [$clog2(N_SAMPLES+1)-1:0] sample_count
);

  localparam int SW    = SAMPLE_W(N_SAMPLES);
  localparam int CW    = CHAN_W(N_CHANNELS);
  localparam int DEPTH = N_SAMPLES * N_CHANNELS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SCW   = $clog2(N_SAMPLES + 1);

  if (WORD_WIDTH % IN_WIDTH != 0) begin : g_width_check
    $error("WORD_WIDTH must be a multiple of IN_WIDTH");
  end

  state_t                state_q, state_d;
  bank_t                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  beat, accept, write_fire, last_word, release_fire;
  logic                  word_vld, chan_wrap, samp_wrap, rd_in_range;
  logic [WORD_WIDTH-1:0] word_dat;
  logic [SW-1:0]         samp_cnt;
  logic [CW-1:0]         chan_cnt;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [31:0]           rs_ext, rc_ext;

  logic [WORD_WIDTH-1:0] mem [2][DEPTH];

  // flush takes priority over a beat and over a word waiting to be written
  assign beat         = enable && in_valid && !flush;
  assign accept       = beat && (state_q == FILL);
  assign write_fire   = word_vld && !flush && (state_q == FILL);
  assign last_word    = write_fire && chan_wrap && samp_wrap;
  assign release_fire = frame_release && frame_ready_q;

  word_assembler #(.IN_WIDTH(IN_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_asm (
    .clk(clk), .rst(rst), .clr(flush), .beat_vld(accept), .beat_dat(in_data),
    .word_vld(word_vld), .word_dat(word_dat)
  );

  up_counter #(.W(CW), .MAX(N_CHANNELS - 1)) u_chan_cnt (
    .clk(clk), .rst(rst), .clr(flush), .inc(write_fire),
    .count(chan_cnt), .wrap(chan_wrap)
  );

  up_counter #(.W(SW), .MAX(N_SAMPLES - 1)) u_samp_cnt (
    .clk(clk), .rst(rst), .clr(flush), .inc(write_fire && chan_wrap),
    .count(samp_cnt), .wrap(samp_wrap)
  );

  assign wr_addr     = AW'(samp_cnt) * AW'(N_CHANNELS) + AW'(chan_cnt);
  assign rd_addr     = AW'(rd_sample) * AW'(N_CHANNELS) + AW'(rd_channel);
  assign rs_ext      = 32'(rd_sample);
  assign rc_ext      = 32'(rd_channel);
  assign rd_in_range = (rs_ext < 32'(N_SAMPLES)) && (rc_ext < 32'(N_CHANNELS));

  always_ff @(posedge clk) begin
    if (write_fire) begin
      mem[wr_bank_q][wr_addr] <= word_dat;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (release_fire) begin
      full_d[rd_bank_q] = 1'b0;
    end
    // a release in the completion cycle counts toward freeing the other bank
    if (last_word) begin
      full_d[wr_bank_q] = 1'b1;
      if ((DOUBLE_BUFFER != 0) && !full_d[~wr_bank_q]) begin
        wr_bank_d = ~wr_bank_q;
      end else begin
        state_d = WAIT;
      end
    end else if ((state_q == WAIT) && release_fire) begin
      state_d   = FILL;
      wr_bank_d = rd_bank_q;
    end
    rd_bank_d = rd_bank_q;
    if (!full_d[rd_bank_q] && full_d[~rd_bank_q]) begin
      rd_bank_d = ~rd_bank_q;
    end
    frame_ready_d = full_d[rd_bank_d];
    overrun_d     = beat && (state_q == WAIT);
    rd_valid_d    = rd_en && frame_ready_q;
    rd_data_d     = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = rd_in_range ? mem[rd_bank_q][rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign frame_ready  = frame_ready_q;
  assign overrun      = overrun_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign sample_count = SCW'(samp_cnt);

endmodule
